// File: rtl/alarm_pkg.sv
// Shared definitions for the anti-theft alarm sequencer: state codes,
// parameter-store interval selects and the timer/parameter width.
package alarm_pkg;

  localparam int TW = 4;

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_SOUND      = 3'd2,
    ST_SOUND_HOLD = 3'd3,
    ST_DISARMED   = 3'd4,
    ST_WAIT_OPEN  = 3'd5,
    ST_WAIT_CLOSE = 3'd6,
    ST_ARM_WAIT   = 3'd7
  } state_e;

  localparam logic [1:0] INT_ARM      = 2'b00;
  localparam logic [1:0] INT_DRIVER   = 2'b01;
  localparam logic [1:0] INT_PASS     = 2'b10;
  localparam logic [1:0] INT_ALARM_ON = 2'b11;

  // States that own a running countdown; leaving them abandons the timer.
  function automatic logic is_timed(input state_e s);
    return (s == ST_TRIGGERED) || (s == ST_SOUND_HOLD) || (s == ST_ARM_WAIT);
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Seconds countdown: clear wins over load, load wins over tick.
// A loaded value of zero becomes one so every timed interval lasts at
// least one tick. expired_o is combinational so the owner reacts on the
// same edge the count reaches zero.
module countdown_timer
  import alarm_pkg::*;
#(
  parameter int W = TW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic [W-1:0] count_o,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // Count register: clear, load (zero promoted to one), or decrement on tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= (value_i == '0) ? W'(1) : value_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o   = count_q;
  assign expired_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Anti-theft alarm sequencer. Selects a timing parameter through
// `interval`, waits PARAM_LAT clocks for the store, loads the countdown
// and reacts to expiry, doors and ignition.
// Optional macro ALARM_BLINK_EN: status_led blinks at 0.5 Hz in ARMED
// (starting at 1 on entry) instead of staying steadily on.
// Handshake note: there is no valid/ready pair here; the parameter store
// is a fixed-latency lookup, so `param_value` is trusted PARAM_LAT clocks
// after `interval` changes and ticks are ignored until the load lands.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int PARAM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          one_hz_en,
  input  logic          ignition,
  input  logic          door_driver,
  input  logic          door_pass,
  input  logic          reprogram,
  input  logic [TW-1:0] param_value,
  output logic [1:0]    interval,
  output logic          siren,
  output logic          status_led,
  output logic [2:0]    state_dbg
);

  localparam int FW = (PARAM_LAT < 1) ? 1 : $clog2(PARAM_LAT + 1);

  state_e        state_q, state_d;
  logic          fetch_active_q;
  logic [FW-1:0] fetch_cnt_q;
  logic [1:0]    interval_q, interval_d;
  logic          siren_q, siren_d;
  logic          led_q, led_d;

  logic          fetch_start;
  logic [1:0]    fetch_sel;
  logic          next_timed;
  logic          timer_load, timer_clear, timer_tick, timer_expired;
  logic [TW-1:0] timer_count;
  logic          any_door;

  assign any_door = door_driver || door_pass;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reprogram overrides every per-state rule, and door
  // events beat expiry in the timed states that watch doors.
  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    fetch_sel   = INT_ARM;
    if (reprogram) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (door_driver) begin
            state_d     = ST_TRIGGERED;
            fetch_start = 1'b1;
            fetch_sel   = INT_DRIVER;
          end else if (door_pass) begin
            state_d     = ST_TRIGGERED;
            fetch_start = 1'b1;
            fetch_sel   = INT_PASS;
          end
        end
        ST_TRIGGERED: begin
          if (ignition)           state_d = ST_DISARMED;
          else if (timer_expired) state_d = ST_SOUND;
        end
        ST_SOUND: begin
          if (ignition) begin
            state_d = ST_DISARMED;
          end else if (!any_door) begin
            state_d     = ST_SOUND_HOLD;
            fetch_start = 1'b1;
            fetch_sel   = INT_ALARM_ON;
          end
        end
        ST_SOUND_HOLD: begin
          if (any_door)           state_d = ST_SOUND;
          else if (ignition)      state_d = ST_DISARMED;
          else if (timer_expired) state_d = ST_ARMED;
        end
        ST_DISARMED: begin
          if (!ignition) state_d = ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (ignition)         state_d = ST_DISARMED;
          else if (door_driver) state_d = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_d = ST_DISARMED;
          end else if (!door_driver) begin
            state_d     = ST_ARM_WAIT;
            fetch_start = 1'b1;
            fetch_sel   = INT_ARM;
          end
        end
        ST_ARM_WAIT: begin
          if (ignition) begin
            state_d = ST_DISARMED;
          end else if (any_door) begin
            fetch_start = 1'b1;
            fetch_sel   = INT_ARM;
          end else if (timer_expired) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // Output and timer-control decode from the chosen next state.
  always_comb begin
    next_timed  = is_timed(state_d);
    siren_d     = (state_d == ST_SOUND) || (state_d == ST_SOUND_HOLD);
    interval_d  = fetch_start ? fetch_sel : interval_q;
    timer_clear = fetch_start || !next_timed;
    timer_load  = fetch_active_q && (fetch_cnt_q == '0) && !fetch_start && next_timed;
    timer_tick  = one_hz_en && !fetch_active_q && (timer_count != '0);
`ifdef ALARM_BLINK_EN
    if (state_d != ST_ARMED)      led_d = 1'b0;
    else if (state_q != ST_ARMED) led_d = 1'b1;
    else if (one_hz_en)           led_d = !led_q;
    else                          led_d = led_q;
`else
    led_d = (state_d == ST_ARMED);
`endif
  end

  // Registered outputs and the parameter-fetch latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_q     <= INT_ARM;
      siren_q        <= 1'b0;
      led_q          <= 1'b1;
      fetch_active_q <= 1'b0;
      fetch_cnt_q    <= '0;
    end else begin
      interval_q <= interval_d;
      siren_q    <= siren_d;
      led_q      <= led_d;
      if (fetch_start) begin
        fetch_active_q <= 1'b1;
        fetch_cnt_q    <= FW'(PARAM_LAT);
      end else if (!next_timed || timer_load) begin
        fetch_active_q <= 1'b0;
        fetch_cnt_q    <= '0;
      end else if (fetch_active_q && (fetch_cnt_q != '0)) begin
        fetch_cnt_q <= fetch_cnt_q - FW'(1);
      end
    end
  end

  countdown_timer #(.W(TW)) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (timer_clear),
    .load_i    (timer_load),
    .value_i   (param_value),
    .tick_i    (timer_tick),
    .count_o   (timer_count),
    .expired_o (timer_expired)
  );

  assign interval   = interval_q;
  assign siren      = siren_q;
  assign status_led = led_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Anti-theft controller FSM that sequences the time-parameter store and owns a 4-bit seconds countdown.
- Drives `interval[1:0]` to the parameter store, fetches the returned 4-bit `value`, loads it into the countdown and reacts to expiry.
- Outputs: siren drive, status LED and a debug state code.
- Sits between the debounced/synchronized switch inputs, the 1 Hz divider and the parameter store.

Parameters:
- PARAM_LAT, 2: clocks from `interval` change to a valid `param_value`.
- TW, 4: timer and parameter width in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- one_hz_en  in  1  single-cycle 1 Hz enable pulse
- ignition  in  1  ignition switch, 1 = on
- door_driver  in  1  driver door, 1 = open
- door_pass  in  1  passenger door, 1 = open
- reprogram  in  1  parameter reprogram strobe (level)
- param_value  in  TW  value returned by the parameter store
- interval  out  2  parameter select: 00 ARM, 01 DRIVER, 10 PASSENGER, 11 ALARM_ON
- siren  out  1  siren drive
- status_led  out  1  armed indicator
- state_dbg  out  3  current state code

Behaviour:
- All outputs are registered.
- Reset values: state ARMED, `interval`=00, `siren`=0, `status_led`=1, timer=0, fetch counter idle.
- State codes: ARMED=0, TRIGGERED=1, SOUND=2, SOUND_HOLD=3, DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_WAIT=7.
- Timed-interval start (fetch):
  - Drive `interval`, hold it, load fetch_cnt=PARAM_LAT.
  - When fetch_cnt reaches 0, load the timer from `param_value`.
  - While fetching, `one_hz_en` is ignored and no expiry occurs.
  - A loaded value of 0 is treated as 1.
- Timer:
  - Decrements on `one_hz_en`.
  - `expired` is a one-cycle pulse on the tick that takes the count 1 -> 0.
- Transitions, top priority first:
  - reset
  - `reprogram`=1 -> ARMED, `siren`=0, timer cleared; held in ARMED while `reprogram` stays high.
  - Then the per-state rules below.
- ARMED:
  - `door_driver` -> TRIGGERED, interval 01.
  - Else `door_pass` -> TRIGGERED, interval 10.
  - Both doors in the same cycle: driver wins.
  - `ignition` is ignored.
- TRIGGERED:
  - `ignition` -> DISARMED.
  - `expired` -> SOUND with `siren`=1.
  - Further door events are ignored.
- SOUND:
  - `siren`=1.
  - `ignition` -> DISARMED, `siren`=0.
  - Both doors closed -> SOUND_HOLD, fetch interval 11.
- SOUND_HOLD:
  - `siren`=1.
  - Any door opens -> SOUND, timer abandoned.
  - `ignition` -> DISARMED.
  - `expired` -> ARMED, `siren`=0.
- DISARMED:
  - `ignition`=0 -> WAIT_OPEN.
- WAIT_OPEN:
  - `ignition`=1 -> DISARMED.
  - `door_driver`=1 -> WAIT_CLOSE.
- WAIT_CLOSE:
  - `ignition`=1 -> DISARMED.
  - `door_driver`=0 -> ARM_WAIT, fetch interval 00.
- ARM_WAIT:
  - `ignition` -> DISARMED.
  - Any door opens -> restart the fetch, interval 00.
  - `expired` -> ARMED.
- `status_led`: 1 in ARMED, 0 elsewhere (see optional feature).
- Expiry and door-open in the same cycle in ARM_WAIT/SOUND_HOLD: the door wins.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined: in ARMED, `status_led` toggles on every `one_hz_en` (0.5 Hz blink); on entering ARMED it starts at 1.
- Undefined: `status_led` is steady 1 in ARMED.
- With or without the macro, `status_led` is 0 outside ARMED.

Decomposition:
- Shared package `alarm_pkg`:
  - state enum and codes
  - interval encodings (INT_ARM, INT_DRIVER, INT_PASS, INT_ALARM_ON)
  - TW
- Sub-module `countdown_timer`: load/value/tick -> count and expired pulse, with asynchronous reset.
- The FSM and fetch counter stay in `alarm_sequencer`.

Test Plan:
- Reset, then `door_driver`=1 with `param_value` model (ARM 6, DRIVER 8, PASS 15, ALARM_ON 10) -> `interval`=01 for PARAM_LAT clocks, `siren` rises on the 8th tick after load; `state_dbg` 0->1->2.
- From SOUND, close doors, 10 ticks -> `siren` falls exactly on the 10th tick, state 0; reopen at tick 5 -> back to SOUND, `siren` stays 1.
- ARMED, `door_pass`=1, `ignition`=1 at tick 3 -> DISARMED, `siren` never asserts; ignition off, driver opens, closes, 6 ticks -> ARMED.
- ARM_WAIT, passenger opens at tick 4 -> interval re-fetched, ARMED only 6 full ticks after the door closes.
- `reprogram` pulse in SOUND -> next clock ARMED, `siren`=0; `reset` mid-countdown -> all outputs at reset values immediately (asynchronous).
- Both doors open in the same cycle in ARMED -> `interval`=01; `param_value`=0 loaded -> expires on the first tick.
